ex_mem_result_stage: RTL and testbench

// - EX->MEM pipeline stage sitting directly downstream of the 64-bit ALU adder.
// - Registers the adder sum and destination info, derives N/Z from the sum and takes C/V from adder co_flag/of_flag.
// - Holds the architectural NZCV flag register, written only by flag-setting instructions (ADDS/SUBS).
// - Evaluates the B.cond condition for the decode stage, with a same-cycle flag bypass from EX.

---
 rtl/ex_mem_result_stage.sv | 88 ++++++++
 tb/tb_ex_mem_result_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_result_stage.sv
// EX->MEM pipeline register for the ALU adder result, plus the architectural
// NZCV flag register and B.cond evaluation with a same-cycle flag bypass from EX.
module ex_mem_result_stage #(
  parameter int unsigned N      = 64,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      alu_result,
  input  logic              co_flag,
  input  logic              of_flag,
  input  logic              valid_in,
  input  logic              set_flags,
  input  logic              reg_write_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              stall,
  input  logic              flush,
  input  logic [3:0]        cond,
  output logic [N-1:0]      result_q,
  output logic [REG_AW-1:0] rd_q,
  output logic              reg_write_q,
  output logic              valid_q,
  output logic [3:0]        flags_q,
  output logic              cond_true
);

  logic [3:0] ex_flags;
  logic [3:0] fwd_flags;
  logic       ex_sets_flags;
  logic       f_n, f_z, f_c, f_v;

  // C and V come straight from the adder; for SUBS its carry is already "no borrow"
  always_comb begin
    ex_flags      = {alu_result[N-1], (alu_result == '0), co_flag, of_flag};
    ex_sets_flags = valid_in & set_flags;
  end

  // Bypass ignores stall: a held flag-setting instruction still steers branches
  always_comb begin
    fwd_flags = (ex_sets_flags & ~flush) ? ex_flags : flags_q;
    {f_n, f_z, f_c, f_v} = fwd_flags;
  end

  always_comb begin
    cond_true = 1'b1;
    case (cond)
      4'b0000: cond_true = f_z;
      4'b0001: cond_true = ~f_z;
      4'b0010: cond_true = f_c;
      4'b0011: cond_true = ~f_c;
      4'b0100: cond_true = f_n;
      4'b0101: cond_true = ~f_n;
      4'b0110: cond_true = f_v;
      4'b0111: cond_true = ~f_v;
      4'b1000: cond_true = f_c & ~f_z;
      4'b1001: cond_true = ~(f_c & ~f_z);
      4'b1010: cond_true = (f_n == f_v);
      4'b1011: cond_true = (f_n != f_v);
      4'b1100: cond_true = ~f_z & (f_n == f_v);
      4'b1101: cond_true = ~(~f_z & (f_n == f_v));
      default: cond_true = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q    <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      valid_q     <= 1'b0;
      flags_q     <= '0;
    end else if (flush) begin
      // Bubble: result_q and flags_q deliberately keep their values
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      valid_q     <= 1'b0;
    end else if (!stall) begin
      result_q    <= alu_result;
      rd_q        <= rd_in;
      reg_write_q <= reg_write_in & valid_in;
      valid_q     <= valid_in;
      if (ex_sets_flags) begin
        flags_q <= ex_flags;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_result_stage.sv
// Directed bench for ex_mem_result_stage: reference model feeds a scoreboard
// queue at drive time; entries are popped and compared one cycle later.
module tb_ex_mem_result_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] alu_result;
  logic        co_flag, of_flag, valid_in, set_flags, reg_write_in;
  logic [4:0]  rd_in;
  logic        stall, flush;
  logic [3:0]  cond;
  logic [63:0] result_q;
  logic [4:0]  rd_q;
  logic        reg_write_q, valid_q, cond_true;
  logic [3:0]  flags_q;

  int unsigned n_asserts = 0;
  int unsigned n_fail    = 0;

  typedef struct packed {
    logic [63:0] result;
    logic [4:0]  rd;
    logic        rw;
    logic        valid;
    logic [3:0]  flags;
  } exp_t;

  exp_t sb[$];

  logic [63:0] m_result = '0;
  logic [4:0]  m_rd     = '0;
  logic        m_rw     = 1'b0;
  logic        m_valid  = 1'b0;
  logic [3:0]  m_flags  = '0;

  ex_mem_result_stage #(.N(64), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .alu_result(alu_result), .co_flag(co_flag),
    .of_flag(of_flag), .valid_in(valid_in), .set_flags(set_flags),
    .reg_write_in(reg_write_in), .rd_in(rd_in), .stall(stall), .flush(flush),
    .cond(cond), .result_q(result_q), .rd_q(rd_q), .reg_write_q(reg_write_q),
    .valid_q(valid_q), .flags_q(flags_q), .cond_true(cond_true)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] nzcv);
    logic n, z, cy, v;
    {n, z, cy, v} = nzcv;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !(cy && !z);
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return !(!z && (n == v));
      default: return 1'b1;
    endcase
  endfunction

  // Checks cond_true on the current inputs, advances the model, clocks, compares
  task automatic cycle(input string tag);
    exp_t e;
    logic [3:0] nf, fwd;
    nf  = {alu_result[63], alu_result == 64'd0, co_flag, of_flag};
    fwd = (valid_in && set_flags && !flush) ? nf : m_flags;
    #1;
    chk({tag, "/cond_true"}, {63'd0, cond_true}, {63'd0, cond_eval(cond, fwd)});
    if (reset) begin
      m_result = '0; m_rd = '0; m_rw = 1'b0; m_valid = 1'b0; m_flags = '0;
    end else if (flush) begin
      m_rd = '0; m_rw = 1'b0; m_valid = 1'b0;
    end else if (!stall) begin
      m_result = alu_result; m_rd = rd_in; m_valid = valid_in;
      m_rw = reg_write_in && valid_in;
      if (valid_in && set_flags) m_flags = nf;
    end
    e = '{result: m_result, rd: m_rd, rw: m_rw, valid: m_valid, flags: m_flags};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, "/result_q"},    result_q,              e.result);
    chk({tag, "/rd_q"},        {59'd0, rd_q},         {59'd0, e.rd});
    chk({tag, "/reg_write_q"}, {63'd0, reg_write_q},  {63'd0, e.rw});
    chk({tag, "/valid_q"},     {63'd0, valid_q},      {63'd0, e.valid});
    chk({tag, "/flags_q"},     {60'd0, flags_q},      {60'd0, e.flags});
  endtask

  task automatic drive(input logic [63:0] a, input logic c, input logic v,
                       input logic vi, input logic sf, input logic rw,
                       input logic [4:0] rd, input logic st, input logic fl,
                       input logic [3:0] cd);
    alu_result = a; co_flag = c; of_flag = v; valid_in = vi; set_flags = sf;
    reg_write_in = rw; rd_in = rd; stall = st; flush = fl; cond = cd;
  endtask

  logic [63:0] held_result;

  initial begin
    // Reset with random inputs; AL must hold regardless of bypass
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive({$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom),
            1'($urandom), 4'b1110);
      cycle("reset");
    end
    chk("reset_flags_zero", {60'd0, flags_q}, 64'd0);
    reset = 1'b0;

    // Idle after reset: EQ false, AL true from cleared flags
    drive(64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000);
    #1;
    chk("post_reset_eq", {63'd0, cond_true}, 64'd0);
    cond = 4'b1110;
    #1;
    chk("post_reset_al", {63'd0, cond_true}, 64'd1);

    // SUBS 20-20: EQ satisfied through the bypass in the same cycle
    drive(64'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 4'b0000);
    #1;
    chk("subs_bypass_eq", {63'd0, cond_true}, 64'd1);
    cycle("subs");
    chk("subs_flags", {60'd0, flags_q}, 64'h6);
    chk("subs_rd", {59'd0, rd_q}, 64'd3);

    // Plain ADD leaves flags alone
    drive(64'd356, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 4'b0000);
    cycle("add");
    chk("add_flags_kept", {60'd0, flags_q}, 64'h6);
    chk("add_result", result_q, 64'd356);

    // Signed overflow: N=1, V=1 -> flags 1001, so N==V
    drive(64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 4'b1010);
    #1;
    chk("ovf_bypass_ge", {63'd0, cond_true}, 64'd1);
    cycle("ovf");
    chk("ovf_flags", {60'd0, flags_q}, 64'h9);
    valid_in = 1'b0;
    cond = 4'b0110; #1;
    chk("ovf_vs", {63'd0, cond_true}, 64'd1);
    cond = 4'b1011; #1;
    chk("ovf_lt", {63'd0, cond_true}, 64'd0);
    cond = 4'b1000; #1;
    chk("ovf_hi", {63'd0, cond_true}, 64'd0);

    // Stall for 3 cycles with a flag-setting instruction held in EX
    held_result = result_q;
    for (int i = 0; i < 3; i++) begin
      drive(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 4'(i * 4 + 1));
      cycle("stall");
    end
    chk("stall_result_held", result_q, held_result);
    chk("stall_flags_held", {60'd0, flags_q}, 64'h9);

    // Flush wins over stall; flags untouched, result held
    drive(64'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd11, 1'b1, 1'b1, 4'b0000);
    cycle("flush");
    chk("flush_valid", {63'd0, valid_q}, 64'd0);
    chk("flush_flags", {60'd0, flags_q}, 64'h9);
    chk("flush_result_held", result_q, held_result);

    // Mixed traffic
    for (int i = 0; i < 40; i++) begin
      drive((i % 5 == 0) ? 64'd0 : {$urandom, $urandom}, 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 5'($urandom),
            1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0), 4'($urandom));
      cycle("traffic");
    end

    // Establish nonzero flags, then reset together with stall
    drive(64'hF000_0000_0000_0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd17, 1'b0, 1'b0, 4'b1111);
    cycle("pre_reset");
    chk("pre_reset_flags", {60'd0, flags_q}, 64'hB);
    reset = 1'b1;
    drive(64'd123, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd21, 1'b1, 1'b0, 4'b1110);
    cycle("mid_reset");
    chk("mid_reset_flags", {60'd0, flags_q}, 64'd0);
    chk("mid_reset_result", result_q, 64'd0);
    reset = 1'b0;
    drive(64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000);
    cycle("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
